// File: rtl/rr_grant_scheduler.sv
// ---------------------------------------------------------------------------
// rr_grant_scheduler
//   Four-requester round-robin scheduler for one shared resource. While idle it
//   rotates the request vector by a priority pointer and takes the lowest set
//   bit. The winner keeps a registered one-hot grant until it drops its request
//   or has held the grant for MAX_HOLD cycles.
//
// Ports
//   clk          in   1  rising-edge clock
//   rst_n        in   1  asynchronous active-low reset
//   req          in   4  request vector, bit i = requester i
//   grant        out  4  registered one-hot grant (or zero)
//   grant_id     out  2  index of granted requester, valid with grant_valid
//   grant_valid  out  1  high whenever any grant bit is high
//   timeout      out  1  one-cycle pulse after a grant is revoked by hold limit
// ---------------------------------------------------------------------------
module rr_grant_scheduler #(
    parameter int unsigned MAX_HOLD = 15,
    parameter int unsigned HOLD_W   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] grant_id,
    output logic       grant_valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t            state_q, state_d;
    logic [3:0]        grant_q, grant_d;
    logic [1:0]        grant_id_q, grant_id_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              timeout_q, timeout_d;

    logic [7:0]        req_dbl;
    logic [3:0]        rot;
    logic [1:0]        idx;
    logic [1:0]        winner;

    // Rotate right by ptr: rot[i] = req[(i + ptr) mod 4].
    always_comb begin
        req_dbl = {req, req} >> ptr_q;
        rot     = req_dbl[3:0];
    end

    // LSB-first search within the rotated vector, then undo the rotation.
    always_comb begin
        idx = 2'd3;
        if (rot[0]) begin
            idx = 2'd0;
        end else if (rot[1]) begin
            idx = 2'd1;
        end else if (rot[2]) begin
            idx = 2'd2;
        end
        winner = ptr_q + idx;
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req != 4'b0000) begin
                    state_d    = GRANT;
                    grant_d    = 4'b0001 << winner;
                    grant_id_d = winner;
                    ptr_d      = winner + 2'd1;
                    hold_cnt_d = '0;
                end
            end
            GRANT: begin
                // Release wins over timeout when both happen on the same edge.
                if (!req[grant_id_q]) begin
                    state_d    = IDLE;
                    grant_d    = '0;
                    grant_id_d = '0;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = IDLE;
                    grant_d    = '0;
                    grant_id_d = '0;
                    timeout_d  = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            grant_id_q <= '0;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign grant       = grant_q;
    assign grant_id    = grant_id_q;
    assign grant_valid = |grant_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// ---------------------------------------------------------------------------
// tb_rr_grant_scheduler
//   Bench for rr_grant_scheduler: directed scenarios with literal expectations
//   followed by randomized requests and occasional asynchronous resets, with a
//   behavioural model compared against the DUT on every falling edge.
// ---------------------------------------------------------------------------
module tb_rr_grant_scheduler;

    localparam int MAX_HOLD = 15;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       grant_valid;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    rr_grant_scheduler #(
        .MAX_HOLD(MAX_HOLD),
        .HOLD_W  (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .grant      (grant),
        .grant_id   (grant_id),
        .grant_valid(grant_valid),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: who owns the resource, how many cycles it has held
    // it, and which requester is searched first next time.
    int m_owner   = -1;
    int m_ptr     = 0;
    int m_held    = 0;
    bit m_timeout = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        int w;
        if (!rst_n) begin
            m_owner   <= -1;
            m_ptr     <= 0;
            m_held    <= 0;
            m_timeout <= 1'b0;
        end else begin
            m_timeout <= 1'b0;
            if (m_owner < 0) begin
                w = -1;
                for (int i = 0; i < 4; i++) begin
                    if (w < 0 && req[(m_ptr + i) % 4]) w = (m_ptr + i) % 4;
                end
                if (w >= 0) begin
                    m_owner <= w;
                    m_ptr   <= (w + 1) % 4;
                    m_held  <= 1;
                end
            end else if (!req[m_owner]) begin
                m_owner <= -1;
            end else if (m_held == MAX_HOLD) begin
                m_owner   <= -1;
                m_timeout <= 1'b1;
            end else begin
                m_held <= m_held + 1;
            end
        end
    end

    // Single compare process against the model.
    always @(negedge clk) begin
        logic [3:0] exp_grant;
        exp_grant = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
        check("cmp_grant", {28'd0, grant}, {28'd0, exp_grant});
        check("cmp_valid", {31'd0, grant_valid}, {31'd0, (exp_grant != 4'b0000)});
        if (m_owner >= 0) check("cmp_id", {30'd0, grant_id}, m_owner);
        check("cmp_timeout", {31'd0, timeout}, {31'd0, m_timeout});
        check("cmp_onehot0", {31'd0, $onehot0(grant)}, 32'd1);
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [3:0] seq1 [9];
    int n;

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        seq1  = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                  4'b0000, 4'b1000, 4'b0000, 4'b0001};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_grant", {28'd0, grant}, 32'd0);
        check("rst_valid", {31'd0, grant_valid}, 32'd0);
        check("rst_id", {30'd0, grant_id}, 32'd0);
        check("rst_timeout", {31'd0, timeout}, 32'd0);
        rst_n = 1'b1;

        // 1: all requesting, each winner releases after one cycle
        req = 4'b1111;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            check("t1_seq", {28'd0, grant}, {28'd0, seq1[i]});
            req = grant_valid ? (4'b1111 & ~grant) : 4'b1111;
        end

        // 2: pointer at 2 wraps past 3 to 0, then pointer is 1
        do_reset();
        req = 4'b0010;
        @(negedge clk);
        check("t2_first", {28'd0, grant}, 32'h2);
        req = 4'b0000;
        @(negedge clk);
        req = 4'b0011;
        @(negedge clk);
        check("t2_wrap", {28'd0, grant}, 32'h1);
        check("t2_id", {30'd0, grant_id}, 32'd0);
        req = 4'b0000;
        @(negedge clk);
        req = 4'b0011;
        @(negedge clk);
        check("t2_ptr1", {28'd0, grant}, 32'h2);
        req = 4'b0000;
        @(negedge clk);

        // 3: held request hits the hold limit
        do_reset();
        req = 4'b0100;
        n   = 0;
        @(negedge clk);
        for (int i = 0; i < 20 && grant == 4'b0100; i++) begin
            n++;
            @(negedge clk);
        end
        check("t3_hold_len", n, MAX_HOLD);
        check("t3_timeout", {31'd0, timeout}, 32'd1);
        check("t3_idle", {28'd0, grant}, 32'd0);
        @(negedge clk);
        check("t3_regrant", {28'd0, grant}, 32'h4);
        check("t3_timeout_clr", {31'd0, timeout}, 32'd0);
        req = 4'b0000;
        @(negedge clk);

        // 4: other requests are ignored while granted
        do_reset();
        req = 4'b0010;
        @(negedge clk);
        check("t4_grant1", {28'd0, grant}, 32'h2);
        for (int i = 0; i < 8; i++) begin
            req = {2'($urandom_range(0, 3)), 2'b10};
            @(negedge clk);
            check("t4_hold", {28'd0, grant}, 32'h2);
        end
        req = 4'b0100;
        @(negedge clk);
        check("t4_release", {28'd0, grant}, 32'd0);
        @(negedge clk);
        check("t4_next", {28'd0, grant}, 32'h4);
        req = 4'b0000;
        @(negedge clk);

        // 5: release on the same edge as the hold limit
        do_reset();
        req = 4'b0001;
        for (int i = 0; i < MAX_HOLD; i++) begin
            @(negedge clk);
            check("t5_held", {28'd0, grant}, 32'h1);
        end
        req = 4'b0000;
        @(negedge clk);
        check("t5_grant", {28'd0, grant}, 32'd0);
        check("t5_no_timeout", {31'd0, timeout}, 32'd0);

        // 6: asynchronous reset mid-grant
        do_reset();
        req = 4'b0010;
        @(negedge clk);
        check("t6_grant1", {28'd0, grant}, 32'h2);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_grant", {28'd0, grant}, 32'd0);
        check("t6_async_valid", {31'd0, grant_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        req   = 4'b1000;
        @(negedge clk);
        check("t6_after", {28'd0, grant}, 32'h8);
        req = 4'b0000;
        @(negedge clk);
        req = 4'b1001;
        @(negedge clk);
        check("t6_ptr0", {28'd0, grant}, 32'h1);
        req = 4'b0000;
        @(negedge clk);

        // Randomized phase
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 499) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
            if ($urandom_range(0, 3) == 0) begin
                req = 4'($urandom_range(0, 15));
            end
        end
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
